// File: rtl/o_buf_ds_arbiter_if.sv
// o_buf_ds_arbiter_if: bundles the requester-side and pad-side signals of the
// differential output-buffer arbiter.
//   REQ        per-requester frame request (level)
//   DATA       per-requester serial data bit
//   GNT        one-hot grant back to the requesters
//   FRAME_DONE one-cycle pulse when the last bit of a frame is sampled
//   BUSY       arbiter is sending a frame or waiting out the idle gap
//   BUF_I      registered data to the buffer I input
//   BUF_EN     registered enable to the buffer EN input
// Modport master is the arbiter side; slave is the requester/pad side.
interface o_buf_ds_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0] REQ;
  logic [NUM_REQ-1:0] DATA;
  logic [NUM_REQ-1:0] GNT;
  logic               FRAME_DONE;
  logic               BUSY;
  logic               BUF_I;
  logic               BUF_EN;

  modport master (
    input  REQ,
    input  DATA,
    output GNT,
    output FRAME_DONE,
    output BUSY,
    output BUF_I,
    output BUF_EN
  );

  modport slave (
    output REQ,
    output DATA,
    input  GNT,
    input  FRAME_DONE,
    input  BUSY,
    input  BUF_I,
    input  BUF_EN
  );
endinterface

// File: rtl/o_buf_ds_arbiter.sv
// o_buf_ds_arbiter: round-robin arbiter and frame sequencer sharing one
// differential output buffer between NUM_REQ serial requesters. A granted lane
// sends exactly FRAME_LEN bits, then the buffer is held disabled for GAP extra
// cycles before the next grant.
// Ports:
//   CLK    clock, all logic on the rising edge
//   RST_N  synchronous active-low reset
//   bus    o_buf_ds_arbiter_if.master (REQ, DATA in; GNT, FRAME_DONE, BUSY,
//          BUF_I, BUF_EN out, all outputs registered)
module o_buf_ds_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned GAP       = 2
) (
  input logic                CLK,
  input logic                RST_N,
  o_buf_ds_arbiter_if.master bus
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BitW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned GapW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [BitW-1:0]    BitLast = BitW'(FRAME_LEN - 1);
  localparam logic [GapW-1:0]    GapLast = GapW'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic [IdxW-1:0]    IdxLast = IdxW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] Lane0   = {{(NUM_REQ - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e              state_q;
  logic [IdxW-1:0]     rr_q;
  logic [IdxW-1:0]     g_q;
  logic [BitW-1:0]     bit_cnt_q;
  logic [GapW-1:0]     gap_cnt_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic                done_q;
  logic                busy_q;
  logic                buf_i_q;
  logic                buf_en_q;

  logic                any_req;
  logic [IdxW-1:0]     pick;

  // First set request at or after the round-robin pointer, wrapping upward.
  always_comb begin
    int unsigned sum;
    logic [IdxW-1:0] idx;
    any_req = 1'b0;
    pick    = '0;
    sum     = 0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = 32'(rr_q) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = IdxW'(sum);
      if (!any_req && bus.REQ[idx]) begin
        any_req = 1'b1;
        pick    = idx;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= StIdle;
      rr_q      <= '0;
      g_q       <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      gnt_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      buf_i_q   <= 1'b0;
      buf_en_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          buf_en_q <= 1'b0;
          buf_i_q  <= 1'b0;
          if (any_req) begin
            g_q       <= pick;
            gnt_q     <= Lane0 << pick;
            rr_q      <= (pick == IdxLast) ? '0 : pick + 1'b1;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= StSend;
          end
        end
        StSend: begin
          buf_i_q  <= bus.DATA[g_q];
          buf_en_q <= 1'b1;
          if (bit_cnt_q == BitLast) begin
            // Counter holds at its terminal value; the next grant clears it.
            gnt_q     <= '0;
            done_q    <= 1'b1;
            gap_cnt_q <= '0;
            if (GAP > 0) begin
              state_q <= StGap;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        StGap: begin
          buf_en_q <= 1'b0;
          buf_i_q  <= 1'b0;
          if (gap_cnt_q == GapLast) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.GNT        = gnt_q;
  assign bus.FRAME_DONE = done_q;
  assign bus.BUSY       = busy_q;
  assign bus.BUF_I      = buf_i_q;
  assign bus.BUF_EN     = buf_en_q;

endmodule

// File: tb/tb_o_buf_ds_arbiter.sv
// Bench for o_buf_ds_arbiter: a cycle-by-cycle vector table for reset, a single
// frame (default parameters) and a GAP=0 / FRAME_LEN=2 instance, followed by
// hand-written sequences for mid-frame reset, round-robin order, wrap/skip and
// a request dropped mid-frame.
module tb_o_buf_ds_arbiter;

  logic CLK = 1'b0;
  logic RST_N;

  always #5 CLK = ~CLK;

  o_buf_ds_arbiter_if #(.NUM_REQ(4)) b1 ();
  o_buf_ds_arbiter_if #(.NUM_REQ(4)) b2 ();

  o_buf_ds_arbiter #(.NUM_REQ(4), .FRAME_LEN(8), .GAP(2)) dut1 (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (b1)
  );

  o_buf_ds_arbiter #(.NUM_REQ(4), .FRAME_LEN(2), .GAP(0)) dut2 (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (b2)
  );

  typedef struct {
    int         dut;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] data;
    logic [3:0] gnt;
    logic       fd;
    logic       busy;
    logic       bi;
    logic       ben;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  int   grant_order[$];
  int   gnt_lens[$];
  int   ben_lens[$];
  int   gaps[$];
  int   fd_cnt;
  int   inv_err;

  function automatic vec_t mk(int dut, logic rst_n, logic [3:0] req, logic [3:0] data,
                              logic [3:0] gnt, logic fd, logic busy, logic bi, logic ben);
    vec_t v;
    v.dut = dut; v.rst_n = rst_n; v.req = req; v.data = data;
    v.gnt = gnt; v.fd = fd; v.busy = busy; v.bi = bi; v.ben = ben;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Watch dut1 until nframes FRAME_DONE pulses or the cycle budget runs out.
  task automatic observe(input int nframes, input int budget);
    logic [3:0] pg;
    logic       pben;
    int         glen, blen, lowrun;
    bit         seen_ben;
    grant_order.delete(); gnt_lens.delete(); ben_lens.delete(); gaps.delete();
    fd_cnt = 0; inv_err = 0;
    pg = b1.GNT; pben = 1'b0; glen = 0; blen = 0; lowrun = 0; seen_ben = 0;
    for (int c = 0; c < budget && fd_cnt < nframes; c++) begin
      step();
      if (!$onehot0(b1.GNT)) inv_err++;
      if (!b1.BUF_EN && b1.BUF_I) inv_err++;
      if (b1.GNT != 4'b0 && pg == 4'b0)
        for (int l = 0; l < 4; l++) if (b1.GNT[l]) grant_order.push_back(l);
      if (b1.GNT != 4'b0) glen++;
      else if (pg != 4'b0) begin gnt_lens.push_back(glen); glen = 0; end
      if (b1.BUF_EN) begin
        if (!pben && seen_ben) gaps.push_back(lowrun);
        blen++; lowrun = 0; seen_ben = 1;
      end else begin
        if (pben) begin ben_lens.push_back(blen); blen = 0; end
        lowrun++;
      end
      if (b1.FRAME_DONE) fd_cnt++;
      pg = b1.GNT; pben = b1.BUF_EN;
    end
  endtask

  initial begin
    logic [7:0] frame;
    int         cnt;
    int         regrant;
    int         extra_fd;

    RST_N = 1'b0;
    b1.REQ = '0; b1.DATA = '0;
    b2.REQ = '0; b2.DATA = '0;

    // Reset with activity on the inputs, then one idle cycle.
    vecs.push_back(mk(1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 4'b1111, 4'b1010, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 4'b1010, 4'b0111, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0));
    // Single frame on lane 2, LSB first; other lanes held at 1.
    frame = 8'b10110010;
    vecs.push_back(mk(1, 1, 4'b0100, 4'b1011, 4'b0100, 0, 1, 0, 0));
    for (int n = 0; n < 8; n++)
      vecs.push_back(mk(1, 1, 4'b0000, {1'b1, frame[n], 2'b11},
                        (n < 7) ? 4'b0100 : 4'b0000, n == 7, 1, frame[n], 1));
    vecs.push_back(mk(1, 1, 4'b0000, 4'b1111, 4'b0000, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 4'b0000, 4'b1111, 4'b0000, 0, 0, 0, 0));
    // GAP=0, FRAME_LEN=2 instance, lanes 0 and 1 alternating; lane 0 sends 1s.
    vecs.push_back(mk(2, 1, 4'b0011, 4'b0001, 4'b0001, 0, 1, 0, 0));
    vecs.push_back(mk(2, 1, 4'b0011, 4'b0001, 4'b0001, 0, 1, 1, 1));
    vecs.push_back(mk(2, 1, 4'b0011, 4'b0001, 4'b0000, 1, 0, 1, 1));
    vecs.push_back(mk(2, 1, 4'b0011, 4'b0001, 4'b0010, 0, 1, 0, 0));
    vecs.push_back(mk(2, 1, 4'b0011, 4'b0001, 4'b0010, 0, 1, 0, 1));
    vecs.push_back(mk(2, 1, 4'b0011, 4'b0001, 4'b0000, 1, 0, 0, 1));
    vecs.push_back(mk(2, 1, 4'b0011, 4'b0001, 4'b0001, 0, 1, 0, 0));

    foreach (vecs[i]) begin
      RST_N = vecs[i].rst_n;
      if (vecs[i].dut == 1) begin
        b1.REQ = vecs[i].req; b1.DATA = vecs[i].data;
      end else begin
        b2.REQ = vecs[i].req; b2.DATA = vecs[i].data;
      end
      step();
      if (vecs[i].dut == 1)
        check($sformatf("vec%0d {gnt,fd,busy,bi,en}", i),
              {b1.GNT, b1.FRAME_DONE, b1.BUSY, b1.BUF_I, b1.BUF_EN},
              {vecs[i].gnt, vecs[i].fd, vecs[i].busy, vecs[i].bi, vecs[i].ben});
      else
        check($sformatf("vec%0d {gnt,fd,busy,bi,en}", i),
              {b2.GNT, b2.FRAME_DONE, b2.BUSY, b2.BUF_I, b2.BUF_EN},
              {vecs[i].gnt, vecs[i].fd, vecs[i].busy, vecs[i].bi, vecs[i].ben});
    end
    b2.REQ = '0;

    // Mid-frame reset: pointer is 3, so REQ=0010 wraps to lane 1.
    b1.REQ = 4'b0010; b1.DATA = 4'b0010;
    step();
    check("wrap_grant_lane1", b1.GNT, 4'b0010);
    b1.REQ = 4'b0000;
    repeat (4) step();
    check("en_before_reset", b1.BUF_EN, 1'b1);
    RST_N = 1'b0;
    step();
    check("midframe_reset_outs",
          {b1.GNT, b1.FRAME_DONE, b1.BUSY, b1.BUF_I, b1.BUF_EN}, 8'h00);
    RST_N = 1'b1;

    // Round robin from a freshly reset pointer.
    b1.REQ = 4'b1111; b1.DATA = 4'b0101;
    observe(5, 200);
    check("rr_frames", fd_cnt, 5);
    check("rr_ngrants", grant_order.size(), 5);
    foreach (grant_order[i]) check($sformatf("rr_order%0d", i), grant_order[i], i % 4);
    check("rr_ngaps", gaps.size(), 4);
    foreach (gaps[i]) check($sformatf("rr_gap%0d", i), gaps[i], 3);
    foreach (gnt_lens[i]) check($sformatf("rr_gntlen%0d", i), gnt_lens[i], 8);
    foreach (ben_lens[i]) check($sformatf("rr_enlen%0d", i), ben_lens[i], 8);
    check("rr_invariants", inv_err, 0);

    // Wrap/skip: pointer is 1 after the grant to 0.
    b1.REQ = 4'b1001;
    observe(4, 150);
    check("ws_frames", fd_cnt, 4);
    check("ws_ngrants", grant_order.size(), 4);
    foreach (grant_order[i])
      check($sformatf("ws_order%0d", i), grant_order[i], (i % 2 == 0) ? 3 : 0);
    foreach (gaps[i]) check($sformatf("ws_gap%0d", i), gaps[i], 3);
    check("ws_invariants", inv_err, 0);

    // Request dropped during bit 3 of lane 1's frame.
    b1.REQ = 4'b0010;
    for (int w = 0; w < 20; w++) begin
      step();
      if (b1.GNT != 4'b0) break;
    end
    check("drop_grant", b1.GNT, 4'b0010);
    repeat (3) step();
    b1.REQ = 4'b0000;
    cnt = 3;
    for (int w = 0; w < 20; w++) begin
      step();
      cnt++;
      if (b1.FRAME_DONE) break;
    end
    check("drop_frame_len", cnt, 8);
    check("drop_gnt_at_done", b1.GNT, 4'b0000);
    regrant = 0; extra_fd = 0;
    for (int w = 0; w < 20; w++) begin
      step();
      if (b1.GNT != 4'b0) regrant++;
      if (b1.FRAME_DONE) extra_fd++;
    end
    check("drop_no_regrant", regrant, 0);
    check("drop_single_done", extra_fd, 0);
    check("drop_idle_busy", b1.BUSY, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/o_buf_ds_arbiter.md
Name: o_buf_ds_arbiter

Overview:
- Round-robin arbiter and frame sequencer that shares one differential output buffer (single-ended I/EN into an O_BUF_DS-style P/N pad pair) between NUM_REQ serial requesters.
- Each granted requester sends one fixed-length frame of FRAME_LEN bits.
- A programmable idle gap, with the buffer disabled, follows each frame before the next grant.
- Sits between the fabric-side serial sources and the pad-side differential buffer instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- FRAME_LEN, 8, bits per frame (2..256).
- GAP, 2, extra idle cycles after each frame (0..15).

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST_N  input  1  synchronous active-low reset.
- REQ  input  NUM_REQ  per-requester frame request, level.
- DATA  input  NUM_REQ  per-requester serial data bit; only the granted lane is used.
- GNT  output  NUM_REQ  one-hot grant; lane g drives DATA[g] while GNT[g]=1.
- FRAME_DONE  output  1  one-cycle pulse on the edge the last bit of a frame is sampled.
- BUSY  output  1  high in SEND or GAP.
- BUF_I  output  1  registered data to the buffer I input.
- BUF_EN  output  1  registered enable to the buffer EN input.

Behaviour:
- Reset: sampled RST_N=0 forces the following at that edge:
  - state IDLE; rr pointer = 0; bit counter = 0; gap counter = 0.
  - GNT = 0, FRAME_DONE = 0, BUSY = 0, BUF_I = 0, BUF_EN = 0.
  - Reset mid-frame aborts the frame immediately. No FRAME_DONE is issued.
- States: IDLE, SEND, GAP.
- IDLE:
  - BUF_EN <= 0, BUF_I <= 0.
  - If any REQ bit is high at edge k, pick the first set REQ bit at or after the rr pointer, searching upward with wrap.
  - At edge k: GNT[g] <= 1, rr pointer <= (g+1) mod NUM_REQ, bit counter <= 0, BUSY <= 1, go to SEND.
  - No request: stay in IDLE, outputs unchanged.
- SEND (edges k+1 .. k+FRAME_LEN):
  - Each edge: BUF_I <= DATA[g], BUF_EN <= 1, bit counter increments.
  - The edge on which the counter equals FRAME_LEN-1 is the last-bit edge. At that edge:
    - GNT <= 0, FRAME_DONE <= 1.
    - Go to GAP if GAP>0, else go to IDLE.
  - Frame length is fixed. REQ[g] dropping mid-frame does not shorten or abort the frame.
  - Other REQ bits are ignored until the next IDLE.
- Timing through the frame:
  - GNT[g] is high for exactly FRAME_LEN cycles.
  - BUF_EN is high for exactly FRAME_LEN cycles, lagging GNT by one cycle.
  - BUF_I carries bit n during the (n+1)-th cycle of BUF_EN.
- GAP:
  - Next edge: BUF_EN <= 0, BUF_I <= 0.
  - Stay for GAP edges, then go to IDLE. BUSY <= 0 on the exit edge.
- Inter-frame spacing: minimum BUF_EN-low time between two frames is GAP+1 cycles. With GAP=0, BUSY remains high only through SEND.
- Fairness: a requester holding REQ continuously waits at most NUM_REQ-1 other frames.
- FRAME_DONE is high for exactly one cycle per completed frame.
- Simultaneous events:
  - REQ asserting on the same edge the FSM enters IDLE is not granted until the following edge.
  - RST_N low overrides all other activity.
- Invariants:
  - GNT is always one-hot or zero.
  - BUF_EN=0 implies BUF_I=0.
  - Counter widths are clog2(FRAME_LEN) and clog2(GAP+1). The counters never wrap beyond their terminal values.

Test Plan:
- Reset: hold RST_N=0 for 3 cycles during random REQ/DATA -> GNT=0, BUF_EN=0, BUF_I=0, BUSY=0, FRAME_DONE=0. Repeat mid-frame (at bit 4) -> all outputs zero on the next edge, and the next grant restarts from requester 0.
- Single frame: defaults; REQ=4'b0100 for 1 cycle; lane 2 drives 8'b10110010, LSB first -> GNT=4'b0100 for 8 cycles. BUF_EN is high for 8 cycles one cycle later, with BUF_I = 0,1,0,0,1,1,0,1. FRAME_DONE pulses once. BUSY falls 2 cycles after FRAME_DONE.
- Round-robin: REQ=4'b1111 held -> grant order 0,1,2,3,0. BUF_EN low for exactly 3 cycles between frames. 5 FRAME_DONE pulses.
- Wrap/skip: REQ=4'b1001 held after a grant to 3 -> next grant is 0, then 3, alternating.
- GAP=0, FRAME_LEN=2, REQ=4'b0011 held -> frames alternate 0,1. BUF_EN pattern is 1,1,0,1,1,0. BUSY is low for exactly 1 cycle between frames.
- Request drop: REQ[1] deasserts at bit 3 of its frame -> full 8-bit frame still sent, FRAME_DONE pulses once, no re-grant to 1 while REQ[1]=0.
